// File: rtl/sram_2rw_ctrl.sv
// Two-port read/write SRAM controller: masked writes, fixed-latency reads into per-port
// credit-managed response FIFOs, port 0 priority when both ports write one address.
module sram_2rw_ctrl #(
    parameter int DEPTH        = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_UNIT    = 8,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int MASK_WIDTH  = DATA_WIDTH / MASK_UNIT,
    localparam int QDEPTH      = READ_LATENCY + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_write,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [MASK_WIDTH-1:0] p0_req_mask,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_resp_valid,
    input  logic                  p0_resp_ready,
    output logic [DATA_WIDTH-1:0] p0_resp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_write,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [MASK_WIDTH-1:0] p1_req_mask,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_resp_valid,
    input  logic                  p1_resp_ready,
    output logic [DATA_WIDTH-1:0] p1_resp_rdata,
    output logic [15:0]           conflict_count
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = $clog2(QDEPTH);

    // Handshake: a request fires when req_valid && req_ready at a rising edge; a response
    // pops when resp_valid && resp_ready. Ready may depend on valid (collision stall only).

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req_valid  [2];
    logic                  req_write  [2];
    logic [ADDR_WIDTH-1:0] req_addr   [2];
    logic [MASK_WIDTH-1:0] req_mask   [2];
    logic [DATA_WIDTH-1:0] req_wdata  [2];
    logic                  resp_ready [2];
    logic [DATA_WIDTH-1:0] resp_rdata [2];
    logic [1:0]            req_ready;
    logic [1:0]            base_ready;
    logic [1:0]            wr_en;
    logic [1:0]            resp_valid;
    logic                  collide;

    assign req_valid[0]  = p0_req_valid;
    assign req_valid[1]  = p1_req_valid;
    assign req_write[0]  = p0_req_write;
    assign req_write[1]  = p1_req_write;
    assign req_addr[0]   = p0_req_addr;
    assign req_addr[1]   = p1_req_addr;
    assign req_mask[0]   = p0_req_mask;
    assign req_mask[1]   = p1_req_mask;
    assign req_wdata[0]  = p0_req_wdata;
    assign req_wdata[1]  = p1_req_wdata;
    assign resp_ready[0] = p0_resp_ready;
    assign resp_ready[1] = p1_resp_ready;

    assign collide = p0_req_valid && p0_req_write && base_ready[0] &&
                     p1_req_valid && p1_req_write && (p0_req_addr == p1_req_addr);

    assign p0_req_ready  = base_ready[0];
    assign p1_req_ready  = base_ready[1] && !collide;
    assign req_ready     = {p1_req_ready, p0_req_ready};
    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_rdata = resp_rdata[0];
    assign p1_resp_rdata = resp_rdata[1];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [READ_LATENCY-1:0] pipe_valid;
        logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
        logic [DATA_WIDTH-1:0]   fifo [QDEPTH];
        logic [PTR_W-1:0]        rd_ptr;
        logic [PTR_W-1:0]        wr_ptr;
        logic [CNT_W-1:0]        count;
        logic [CNT_W-1:0]        credits;
        logic                    fire;
        logic                    rd_fire;
        logic                    push;
        logic                    pop;
        logic                    in_range;
        logic [DATA_WIDTH-1:0]   rd_word;

        assign in_range      = {1'b0, req_addr[p]} < (ADDR_WIDTH + 1)'(DEPTH);
        assign base_ready[p] = resetn && (req_write[p] || credits != '0);
        assign fire          = req_valid[p] && req_ready[p];
        assign rd_fire       = fire && !req_write[p];
        assign wr_en[p]      = fire && req_write[p] && in_range;
        assign rd_word       = in_range ? mem[req_addr[p]] : '0;
        assign push          = pipe_valid[READ_LATENCY-1];
        assign resp_valid[p] = count != '0;
        assign pop           = resp_valid[p] && resp_ready[p];
        assign resp_rdata[p] = resp_valid[p] ? fifo[rd_ptr] : '0;

        // rd_word samples memory before this edge's writes land: read-before-write.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                pipe_valid <= '0;
                for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
            end else begin
                pipe_valid[0] <= rd_fire;
                pipe_data[0]  <= rd_word;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                    pipe_data[i]  <= pipe_data[i-1];
                end
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < QDEPTH; i++) fifo[i] <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                credits <= CNT_W'(QDEPTH);
            end else begin
                if (push) begin
                    fifo[wr_ptr] <= pipe_data[READ_LATENCY-1];
                    wr_ptr       <= ptr_next(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_next(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                // Credits cover queue slots plus reads still in the pipeline, so no overflow.
                case ({rd_fire, pop})
                    2'b10:   credits <= credits - 1'b1;
                    2'b01:   credits <= credits + 1'b1;
                    default: credits <= credits;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                for (int l = 0; l < MASK_WIDTH; l++) begin
                    if (req_mask[p][l]) mem[req_addr[p]][l*MASK_UNIT +: MASK_UNIT] <= req_wdata[p][l*MASK_UNIT +: MASK_UNIT];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            conflict_count <= '0;
        end else if (collide && conflict_count != 16'hFFFF) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_sram_2rw_ctrl.sv
// Directed bench for sram_2rw_ctrl: latency, masking, collisions, credits, reset behaviour.
module tb_sram_2rw_ctrl;
    localparam int AW = 10;
    localparam int MW = 4;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          p0_req_valid, p0_req_ready, p0_req_write;
    logic [AW-1:0] p0_req_addr;
    logic [MW-1:0] p0_req_mask;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_resp_valid, p0_resp_ready;
    logic [DW-1:0] p0_resp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_write;
    logic [AW-1:0] p1_req_addr;
    logic [MW-1:0] p1_req_mask;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_resp_valid, p1_resp_ready;
    logic [DW-1:0] p1_resp_rdata;
    logic [15:0]   conflict_count;

    int vectors = 0;
    int miscompares = 0;

    sram_2rw_ctrl dut (
        .clock(clock), .resetn(resetn),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_mask(p0_req_mask), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_mask(p1_req_mask), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
        .conflict_count(conflict_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_req_valid = v; p0_req_write = w; p0_req_addr = a; p0_req_mask = m; p0_req_wdata = d;
        end else begin
            p1_req_valid = v; p1_req_write = w; p1_req_addr = a; p1_req_mask = m; p1_req_wdata = d;
        end
    endtask

    task automatic set_resp_ready(input int p, input logic v);
        if (p == 0) p0_resp_ready = v;
        else        p1_resp_ready = v;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        p0_resp_ready = 1'b0;
        p1_resp_ready = 1'b0;
    endtask

    function automatic logic cur_ready(input int p);
        return (p == 0) ? p0_req_ready : p1_req_ready;
    endfunction

    function automatic logic cur_resp_valid(input int p);
        return (p == 0) ? p0_resp_valid : p1_resp_valid;
    endfunction

    function automatic logic [DW-1:0] cur_rdata(input int p);
        return (p == 0) ? p0_resp_rdata : p1_resp_rdata;
    endfunction

    // Drives one request until it fires; a request that never fires counts as a miscompare.
    task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        int n = 0;
        drive(p, 1'b1, w, a, m, d);
        #1;
        while (!cur_ready(p) && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (n >= 20) begin
            $display("FAIL issue_timeout: port %0d never ready, required ready=1", p);
            miscompares++;
            vectors++;
        end
        tick();
        drive(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Returns data and the number of edges between fire and resp_valid (-1 on timeout), then pops.
    task automatic do_read(input int p, input logic [AW-1:0] a, output logic [DW-1:0] data, output int lat);
        issue(p, 1'b0, a, '0, '0);
        lat  = 0;
        data = '0;
        while (!cur_resp_valid(p) && lat < 20) begin
            tick();
            lat++;
        end
        if (lat >= 20) lat = -1;
        else data = cur_rdata(p);
        set_resp_ready(p, 1'b1);
        tick();
        set_resp_ready(p, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        p0_req_valid = 1'b1;
        p1_req_valid = 1'b1;
        p1_req_write = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (p0_req_ready !== 1'b0) begin $display("FAIL rst_p0_ready: got %0b want 0", p0_req_ready); miscompares++; end
        vectors++; if (p1_req_ready !== 1'b0) begin $display("FAIL rst_p1_ready: got %0b want 0", p1_req_ready); miscompares++; end
        vectors++; if (p0_resp_valid !== 1'b0) begin $display("FAIL rst_p0_resp_valid: got %0b want 0", p0_resp_valid); miscompares++; end
        vectors++; if (p1_resp_valid !== 1'b0) begin $display("FAIL rst_p1_resp_valid: got %0b want 0", p1_resp_valid); miscompares++; end
        vectors++; if (p0_resp_rdata !== 32'h0) begin $display("FAIL rst_p0_rdata: got %h want 0", p0_resp_rdata); miscompares++; end
        vectors++; if (conflict_count !== 16'h0) begin $display("FAIL rst_conflict: got %0d want 0", conflict_count); miscompares++; end
        idle();
        resetn = 1'b1;
        tick();
        #1;
        vectors++; if (p0_req_ready !== 1'b1) begin $display("FAIL post_rst_p0_ready: got %0b want 1", p0_req_ready); miscompares++; end
        vectors++; if (p1_req_ready !== 1'b1) begin $display("FAIL post_rst_p1_ready: got %0b want 1", p1_req_ready); miscompares++; end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        int lat;
        issue(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
        do_read(1, 10'd5, d, lat);
        vectors++; if (lat !== 2) begin $display("FAIL wr_rd_latency: got %0d want 2", lat); miscompares++; end
        vectors++; if (d !== 32'hDEADBEEF) begin $display("FAIL wr_rd_data: got %h want deadbeef", d); miscompares++; end
        do_read(0, 10'd5, d, lat);
        vectors++; if (d !== 32'hDEADBEEF) begin $display("FAIL wr_rd_p0_data: got %h want deadbeef", d); miscompares++; end
        #1;
        vectors++; if (p1_resp_valid !== 1'b0) begin $display("FAIL wr_rd_popped: got %0b want 0", p1_resp_valid); miscompares++; end
    endtask

    task automatic test_mask();
        logic [DW-1:0] d;
        int lat;
        issue(0, 1'b1, 10'd9, 4'hF, 32'h11223344);
        issue(0, 1'b1, 10'd9, 4'h5, 32'hAABBCCDD);
        do_read(0, 10'd9, d, lat);
        vectors++; if (d !== 32'h11BB33DD) begin $display("FAIL mask_merge: got %h want 11bb33dd", d); miscompares++; end
        vectors++; if (lat !== 2) begin $display("FAIL mask_latency: got %0d want 2", lat); miscompares++; end
        issue(1, 1'b1, 10'd9, 4'h0, 32'hFFFFFFFF);
        do_read(1, 10'd9, d, lat);
        vectors++; if (d !== 32'h11BB33DD) begin $display("FAIL mask_zero_noop: got %h want 11bb33dd", d); miscompares++; end
        issue(1, 1'b1, 10'd9, 4'h8, 32'h77000000);
        do_read(0, 10'd9, d, lat);
        vectors++; if (d !== 32'h77BB33DD) begin $display("FAIL mask_top_lane: got %h want 77bb33dd", d); miscompares++; end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] d;
        int lat;
        drive(0, 1'b1, 1'b1, 10'd7, 4'hF, 32'h1);
        drive(1, 1'b1, 1'b1, 10'd7, 4'hF, 32'h2);
        #1;
        vectors++; if (p0_req_ready !== 1'b1) begin $display("FAIL conf_p0_ready: got %0b want 1", p0_req_ready); miscompares++; end
        vectors++; if (p1_req_ready !== 1'b0) begin $display("FAIL conf_p1_stall: got %0b want 0", p1_req_ready); miscompares++; end
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        vectors++; if (p1_req_ready !== 1'b1) begin $display("FAIL conf_p1_resume: got %0b want 1", p1_req_ready); miscompares++; end
        vectors++; if (conflict_count !== 16'd1) begin $display("FAIL conf_count: got %0d want 1", conflict_count); miscompares++; end
        tick();
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        do_read(0, 10'd7, d, lat);
        vectors++; if (d !== 32'h2) begin $display("FAIL conf_final: got %h want 00000002", d); miscompares++; end
        drive(0, 1'b1, 1'b1, 10'd10, 4'hF, 32'hA);
        drive(1, 1'b1, 1'b1, 10'd11, 4'hF, 32'hB);
        #1;
        vectors++; if (p1_req_ready !== 1'b1) begin $display("FAIL diff_addr_ready: got %0b want 1", p1_req_ready); miscompares++; end
        tick();
        idle();
        vectors++; if (conflict_count !== 16'd1) begin $display("FAIL diff_addr_count: got %0d want 1", conflict_count); miscompares++; end
        do_read(1, 10'd10, d, lat);
        vectors++; if (d !== 32'hA) begin $display("FAIL diff_addr_p0_word: got %h want 0000000a", d); miscompares++; end
        do_read(0, 10'd11, d, lat);
        vectors++; if (d !== 32'hB) begin $display("FAIL diff_addr_p1_word: got %h want 0000000b", d); miscompares++; end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got [3];
        int n = 0;
        for (int i = 0; i < 4; i++) issue(1, 1'b1, AW'(20 + i), 4'hF, 32'hA0A00000 + i);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, AW'(20 + i), '0, '0);
            #1;
            vectors++; if (p0_req_ready !== 1'b1) begin $display("FAIL b2b_ready_fire%0d: got %0b want 1", i, p0_req_ready); miscompares++; end
            tick();
        end
        drive(0, 1'b1, 1'b0, 10'd23, '0, '0);
        #1;
        vectors++; if (p0_req_ready !== 1'b0) begin $display("FAIL b2b_ready_drop: got %0b want 0", p0_req_ready); miscompares++; end
        vectors++; if (p0_resp_rdata !== 32'hA0A00000 || p0_resp_valid !== 1'b1) begin
            $display("FAIL b2b_head: got valid=%0b data=%h want valid=1 data=a0a00000", p0_resp_valid, p0_resp_rdata); miscompares++; end
        tick();
        tick();
        #1;
        vectors++; if (p0_req_ready !== 1'b0) begin $display("FAIL b2b_ready_held: got %0b want 0", p0_req_ready); miscompares++; end
        p0_resp_ready = 1'b1;
        tick();
        p0_resp_ready = 1'b0;
        #1;
        vectors++; if (p0_req_ready !== 1'b1) begin $display("FAIL b2b_ready_resume: got %0b want 1", p0_req_ready); miscompares++; end
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        p0_resp_ready = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (p0_resp_valid) begin
                got[n] = p0_resp_rdata;
                n++;
            end
            tick();
        end
        p0_resp_ready = 1'b0;
        vectors++; if (n !== 3) begin $display("FAIL b2b_drain_count: got %0d want 3", n); miscompares++; end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i < n && got[i] !== 32'hA0A00001 + i) begin
                $display("FAIL b2b_order%0d: got %h want %h", i, got[i], 32'hA0A00001 + i); miscompares++;
            end
        end
    endtask

    task automatic test_read_before_write();
        logic [DW-1:0] d = '0;
        int lat = 0;
        issue(0, 1'b1, 10'd30, 4'hF, 32'h12345678);
        drive(0, 1'b1, 1'b1, 10'd30, 4'hF, 32'h55);
        drive(1, 1'b1, 1'b0, 10'd30, '0, '0);
        #1;
        vectors++; if (p1_req_ready !== 1'b1) begin $display("FAIL rbw_no_stall: got %0b want 1", p1_req_ready); miscompares++; end
        tick();
        idle();
        while (!p1_resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        d = p1_resp_rdata;
        p1_resp_ready = 1'b1;
        tick();
        p1_resp_ready = 1'b0;
        vectors++; if (d !== 32'h12345678) begin $display("FAIL rbw_old_value: got %h want 12345678", d); miscompares++; end
        vectors++; if (lat !== 2) begin $display("FAIL rbw_latency: got %0d want 2", lat); miscompares++; end
        do_read(1, 10'd30, d, lat);
        vectors++; if (d !== 32'h55) begin $display("FAIL rbw_new_value: got %h want 00000055", d); miscompares++; end
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] first = '0;
        int seen = 0;
        int fires = 0;
        int n = 0;
        drive(0, 1'b1, 1'b0, 10'd20, '0, '0);
        tick();
        drive(0, 1'b1, 1'b0, 10'd21, '0, '0);
        tick();
        idle();
        resetn = 1'b0;
        #1;
        vectors++; if (p0_resp_valid !== 1'b0 || p0_req_ready !== 1'b0) begin
            $display("FAIL rst_mid_outputs: got valid=%0b ready=%0b want 0 0", p0_resp_valid, p0_req_ready); miscompares++; end
        vectors++; if (conflict_count !== 16'd0) begin $display("FAIL rst_mid_conflict: got %0d want 0", conflict_count); miscompares++; end
        tick();
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (p0_resp_valid) seen++;
            tick();
        end
        vectors++; if (seen !== 0) begin $display("FAIL rst_flush: got %0d valid cycles want 0", seen); miscompares++; end
        drive(0, 1'b1, 1'b0, 10'd20, '0, '0);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (p0_req_ready) fires++;
            tick();
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        vectors++; if (fires !== 3) begin $display("FAIL rst_credits: got %0d fires want 3", fires); miscompares++; end
        p0_resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (p0_resp_valid) begin
                if (n == 0) first = p0_resp_rdata;
                n++;
            end
            tick();
        end
        p0_resp_ready = 1'b0;
        vectors++; if (n !== 3) begin $display("FAIL rst_drain_count: got %0d want 3", n); miscompares++; end
        vectors++; if (first !== 32'hA0A00000) begin $display("FAIL rst_mem_kept: got %h want a0a00000", first); miscompares++; end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_mask();
        test_conflict();
        test_back_to_back();
        test_read_before_write();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
